// File: rtl/seq_int_div_if.sv
// rtl/seq_int_div_if.sv - request/result handshake bundle for the sequential divider
interface seq_int_div_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output in_valid, in_signed, a, b, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, in_signed, a, b, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_int_div.sv
// rtl/seq_int_div.sv - restoring sequential integer divider, one quotient bit per cycle
module seq_int_div #(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input logic          clk,
    input logic          rst,
    seq_int_div_if.slave bus
);
    localparam int   CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic SIGNED_ON = (SIGNED_EN != 0);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sign_mode;
    logic [WIDTH-1:0] bmag;
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] quo_w;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_out;
    logic [WIDTH-1:0] rem_out;
    logic             dz_out;

    logic             req_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             step_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign req_signed = bus.in_signed & SIGNED_ON;
    assign a_neg      = sign_mode & a_reg[WIDTH-1];
    assign b_neg      = sign_mode & b_reg[WIDTH-1];

    // The shifted partial remainder can exceed WIDTH bits when |b| is large,
    // so compare in WIDTH+1 bits; the difference itself always fits in WIDTH.
    assign rem_shift  = {rem_w, quo_w[WIDTH-1]};
    assign step_ge    = (rem_shift >= {1'b0, bmag});
    assign rem_diff   = rem_shift[WIDTH-1:0] - bmag;
    assign rem_next   = step_ge ? rem_diff : rem_shift[WIDTH-1:0];
    assign quo_next   = {quo_w[WIDTH-2:0], step_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sign_mode <= 1'b0;
            bmag      <= '0;
            rem_w     <= '0;
            quo_w     <= '0;
            cnt       <= '0;
            quo_out   <= '0;
            rem_out   <= '0;
            dz_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        sign_mode <= req_signed;
                        quo_w     <= (req_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
                        bmag      <= (req_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
                        rem_w     <= '0;
                        cnt       <= CW'(WIDTH - 1);
                        state     <= CALC;
                    end
                end
                CALC: begin
                    // A zero divisor leaves on the first CALC cycle without stepping.
                    if (b_reg == '0) begin
                        quo_out <= '1;
                        rem_out <= a_reg;
                        dz_out  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        rem_w <= rem_next;
                        quo_w <= quo_next;
                        cnt   <= cnt - CW'(1);
                        if (cnt == '0) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    quo_out <= (a_neg ^ b_neg) ? -quo_w : quo_w;
                    rem_out <= a_neg ? -rem_w : rem_w;
                    dz_out  <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = quo_out;
    assign bus.remainder = rem_out;
    assign bus.div_zero  = dz_out;
endmodule

// File: tb/tb_seq_int_div.sv
// tb/tb_seq_int_div.sv - scoreboard bench for seq_int_div at WIDTH 32, 16 and 8
module tb_seq_int_div;
    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb32[$];

    seq_int_div_if #(.WIDTH(32)) if32 ();
    seq_int_div_if #(.WIDTH(16)) if16 ();
    seq_int_div_if #(.WIDTH(8))  if8 ();

    seq_int_div #(.WIDTH(32), .SIGNED_EN(1)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    seq_int_div #(.WIDTH(16), .SIGNED_EN(1)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    seq_int_div #(.WIDTH(8),  .SIGNED_EN(1)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                   input logic sgn);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        longint      sa;
        longint      sbv;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (b == 64'd0) begin
            e.q = mask; e.r = a; e.dz = 1'b1;
        end else if (sgn) begin
            sa  = a << (64 - w);
            sa  = sa >>> (64 - w);
            sbv = b << (64 - w);
            sbv = sbv >>> (64 - w);
            e.q = 64'(sa / sbv) & mask;
            e.r = 64'(sa % sbv) & mask;
            e.dz = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        int n;
        n = 0;
        @(negedge clk);
        while (!if32.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (if32.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send32_in_ready got=%b exp=1", if32.in_ready);
        end
        if32.in_valid  = 1'b1;
        if32.a         = a;
        if32.b         = b;
        if32.in_signed = sgn;
        @(posedge clk);
        sb32.push_back(model(32, {32'd0, a}, {32'd0, b}, sgn));
        #1;
        if32.in_valid  = 1'b0;
        if32.a         = $urandom;
        if32.b         = $urandom;
        if32.in_signed = 1'($urandom_range(0, 1));
    endtask

    // Called right after the accepting edge; exp_lat < 0 skips the latency check.
    task automatic recv32(input int exp_lat, input int hold);
        int          lat;
        exp_t        e;
        logic [31:0] q0;
        logic [31:0] r0;
        logic        d0;
        lat = 0;
        @(negedge clk);
        while (!if32.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (if32.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL recv32_timeout out_valid=%b exp=1", if32.out_valid);
        end
        if (exp_lat >= 0) begin
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL recv32_latency got=%0d exp=%0d", lat, exp_lat);
            end
        end
        checks++;
        if (sb32.size() == 0) begin
            errors++;
            $display("FAIL recv32_scoreboard_empty got=0 exp>=1");
        end else begin
            e = sb32.pop_front();
            if (if32.quotient !== e.q[31:0] || if32.remainder !== e.r[31:0] ||
                if32.div_zero !== e.dz) begin
                errors++;
                $display("FAIL recv32_result got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
                         if32.quotient, if32.remainder, if32.div_zero, e.q[31:0], e.r[31:0], e.dz);
            end
        end
        q0 = if32.quotient;
        r0 = if32.remainder;
        d0 = if32.div_zero;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (if32.quotient !== q0 || if32.remainder !== r0 || if32.div_zero !== d0 ||
                if32.out_valid !== 1'b1 || if32.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle=%0d got q=%h r=%h dz=%b ov=%b ir=%b exp q=%h r=%h dz=%b ov=1 ir=0",
                         i, if32.quotient, if32.remainder, if32.div_zero, if32.out_valid,
                         if32.in_ready, q0, r0, d0);
            end
        end
        if32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if32.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release got ir=%b ov=%b exp ir=1 ov=0", if32.in_ready, if32.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0 || if32.quotient !== 32'd0 ||
            if32.remainder !== 32'd0 || if32.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset32 got ir=%b ov=%b q=%h r=%h dz=%b exp ir=1 ov=0 q=0 r=0 dz=0",
                     if32.in_ready, if32.out_valid, if32.quotient, if32.remainder, if32.div_zero);
        end
        checks++;
        if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if16.in_ready !== 1'b1 ||
            if16.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_small got ir8=%b ov8=%b ir16=%b ov16=%b exp 1 0 1 0",
                     if8.in_ready, if8.out_valid, if16.in_ready, if16.out_valid);
        end
    endtask

    task automatic test_unsigned();
        send32(32'd100, 32'd7, 1'b0);
        recv32(33, 0);
        send32(32'hFFFFFFFF, 32'd16, 1'b0);
        recv32(33, 0);
        send32(32'd5, 32'd9, 1'b0);
        recv32(33, 0);
    endtask

    task automatic test_signed();
        send32(32'hFFFFFFF9, 32'd2, 1'b1);
        recv32(33, 0);
        send32(32'd7, 32'hFFFFFFFE, 1'b1);
        recv32(33, 0);
        send32(32'h80000000, 32'hFFFFFFFF, 1'b1);
        recv32(33, 0);
        send32(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1);
        recv32(33, 0);
    endtask

    task automatic test_div_zero();
        send32(32'hDEADBEEF, 32'd0, 1'b1);
        recv32(1, 0);
        send32(32'd0, 32'd0, 1'b0);
        recv32(1, 0);
    endtask

    task automatic test_hold();
        send32(32'd1000, 32'd3, 1'b0);
        recv32(33, 10);
    endtask

    task automatic test_ignore();
        if32.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        if32.out_ready = 1'b0;
        send32(32'd77777, 32'd13, 1'b0);
        if32.in_valid  = 1'b1;
        if32.a         = 32'd5;
        if32.b         = 32'd0;
        if32.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (if32.in_ready !== 1'b0 || if32.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL ignore_busy cycle=%0d got ir=%b ov=%b exp ir=0 ov=0",
                         i, if32.in_ready, if32.out_valid);
            end
        end
        if32.in_valid  = 1'b0;
        if32.out_ready = 1'b0;
        recv32(-1, 0);
    endtask

    task automatic test_reset_mid_calc();
        exp_t dropped;
        send32(32'd123456, 32'd67, 1'b0);
        dropped = sb32.pop_back();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0 || if32.quotient !== 32'd0 ||
            if32.remainder !== 32'd0 || if32.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_calc got ir=%b ov=%b q=%h r=%h dz=%b exp ir=1 ov=0 q=0 r=0 dz=0 (dropped q=%h)",
                     if32.in_ready, if32.out_valid, if32.quotient, if32.remainder,
                     if32.div_zero, dropped.q[31:0]);
        end
        send32(32'd999, 32'd10, 1'b0);
        recv32(33, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        for (int i = 0; i < 24; i++) begin
            a = (i % 7 == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                default: b = 32'($urandom);
            endcase
            s = 1'($urandom_range(0, 1));
            send32(a, b, s);
            recv32((b == 32'd0) ? 1 : 33, 0);
        end
    endtask

    task automatic test_overflow_w8();
        int lat;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if8.in_valid  = 1'b1;
            if8.a         = 8'h80;
            if8.b         = 8'hFF;
            if8.in_signed = (i == 0);
            @(posedge clk);
            #1 if8.in_valid = 1'b0;
            lat = 0;
            @(negedge clk);
            while (!if8.out_valid && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== 9 || if8.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL w8_latency mode=%0d got=%0d ov=%b exp=9 ov=1", i, lat, if8.out_valid);
            end
            checks++;
            if (if8.quotient !== ((i == 0) ? 8'h80 : 8'h00) ||
                if8.remainder !== ((i == 0) ? 8'h00 : 8'h80) || if8.div_zero !== 1'b0) begin
                errors++;
                $display("FAIL w8_result mode=%0d got q=%h r=%h dz=%b exp q=%h r=%h dz=0", i,
                         if8.quotient, if8.remainder, if8.div_zero,
                         (i == 0) ? 8'h80 : 8'h00, (i == 0) ? 8'h00 : 8'h80);
            end
            if8.out_ready = 1'b1;
            @(posedge clk);
            #1 if8.out_ready = 1'b0;
        end
    endtask

    task automatic test_div_zero_w16();
        int lat;
        @(negedge clk);
        if16.in_valid  = 1'b1;
        if16.a         = 16'h1234;
        if16.b         = 16'h0000;
        if16.in_signed = 1'b0;
        @(posedge clk);
        #1 if16.in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!if16.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 1 || if16.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL w16_dz_latency got=%0d ov=%b exp=1 ov=1", lat, if16.out_valid);
        end
        checks++;
        if (if16.quotient !== 16'hFFFF || if16.remainder !== 16'h1234 || if16.div_zero !== 1'b1) begin
            errors++;
            $display("FAIL w16_dz_result got q=%h r=%h dz=%b exp q=ffff r=1234 dz=1",
                     if16.quotient, if16.remainder, if16.div_zero);
        end
        if16.out_ready = 1'b1;
        @(posedge clk);
        #1 if16.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if32.in_valid = 1'b0; if32.in_signed = 1'b0; if32.a = '0; if32.b = '0; if32.out_ready = 1'b0;
        if16.in_valid = 1'b0; if16.in_signed = 1'b0; if16.a = '0; if16.b = '0; if16.out_ready = 1'b0;
        if8.in_valid  = 1'b0; if8.in_signed  = 1'b0; if8.a  = '0; if8.b  = '0; if8.out_ready  = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_hold();
        test_ignore();
        test_reset_mid_calc();
        test_back_to_back();
        test_overflow_w8();
        test_div_zero_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_int_div.md
SEQ_INT_DIV -- requirements
Module: seq_int_div

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits, legal values 4..64.
REQ-002 Parameter SIGNED_EN, default 1: 1 enables the per-request signed mode; 0 treats every request as unsigned.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present on a, b, in_signed.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_signed  input  1  1 = two's-complement division (ignored when SIGNED_EN=0).
REQ-008 a  input  WIDTH  dividend.
REQ-009 b  input  WIDTH  divisor.
REQ-010 out_valid  output  1  result present on quotient, remainder, div_zero.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 quotient  output  WIDTH  quotient.
REQ-013 remainder  output  WIDTH  remainder.
REQ-014 div_zero  output  1  result came from a zero divisor.

Function
REQ-015 FSM states SHALL be IDLE, CALC, FIX, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 IDLE: on in_valid&&in_ready, SHALL latch a, b and the effective sign mode (in_signed&&SIGNED_EN); inputs are don't-care afterwards.
REQ-017 Latched b!=0: go to CALC, load the magnitudes of a and b (negated when the operand is signed and its MSB is 1), partial remainder 0, iteration counter WIDTH-1.
REQ-018 CALC: one restoring step per cycle: shift {rem, quo} left by 1; if rem >= |b|, subtract |b| and set quotient LSB to 1; decrement counter; after the step with counter 0, go to FIX.
REQ-019 FIX (one cycle): negate the quotient if the operand signs differ; negate the remainder if the dividend was negative; register the results; go to DONE.
REQ-020 Latency: acceptance at edge k SHALL give out_valid=1 after edge k+WIDTH+1, for any WIDTH.
REQ-021 Signed results SHALL truncate toward zero, and the remainder SHALL carry the dividend's sign; a == quotient*b + remainder (mod 2^WIDTH) always.
REQ-022 Signed overflow (a = most-negative, b = -1) SHALL yield quotient = most-negative, remainder = 0, div_zero = 0.
REQ-023 Latched b==0: skip CALC and FIX; go to DONE at the next edge with quotient all ones, remainder = a (raw), div_zero = 1.
REQ-024 DONE: quotient, remainder, div_zero SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 DONE with out_ready=1: go to IDLE; in_ready rises one cycle later; no same-cycle accept-on-release.
REQ-026 out_ready outside DONE and in_valid outside IDLE SHALL be ignored.
REQ-027 div_zero SHALL be 0 for every nonzero divisor.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE and clear quotient, remainder, div_zero, counter and latched operands to 0; in_ready=1, out_valid=0 from the next cycle.
REQ-029 rst SHALL take priority over every handshake, abort any CALC/FIX/DONE operation in progress, and discard its result.

Verification
REQ-030 WIDTH=32, unsigned, a=100, b=7 -> quotient=14, remainder=2, div_zero=0, out_valid first high 33 cycles after acceptance.
REQ-031 WIDTH=32, signed, a=-7, b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); then a=7, b=-2 -> quotient=-3, remainder=1.
REQ-032 WIDTH=8, signed, a=0x80, b=0xFF -> quotient=0x80, remainder=0x00, div_zero=0; the same operands unsigned -> quotient=0x00, remainder=0x80.
REQ-033 b=0, a=0x1234 (WIDTH=16) -> out_valid after 1 cycle, quotient=0xFFFF, remainder=0x1234, div_zero=1.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 on the following cycle.
REQ-035 Assert rst in mid-CALC (cycle 10 of 32) -> next cycle in_ready=1, out_valid=0, outputs 0; a new request then completes correctly.
